// File: rtl/mem_port_arbiter.sv
// Byte-serial arbiter sharing one 256x8 array between fetch and data ports.
// Define ALIGN_CHECK_EN to add d_err and reject misaligned data accesses.
module mem_port_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int STARVE_MAX = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_valid,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_rw,
   input  logic [1:0]        d_size,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_valid,
   output logic [31:0]       d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
`ifdef ALIGN_CHECK_EN
   output logic              d_err,
`endif
   output logic              busy
);

   localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

   typedef enum logic [1:0] {
      S_IDLE,
      S_XFER,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic              dsel_q, dsel_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              rw_q, rw_d;
   logic [31:0]       wbuf_q, wbuf_d;
   logic [2:0]        n_q, n_d;
   logic [2:0]        k_q, k_d;
   logic [23:0]       acc_q, acc_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [31:0]       d_rdata_q, d_rdata_d;

   logic              gnt_d, gnt_f;
   logic [2:0]        f_n, dn;
   logic [31:0]       wal;
   logic              unused;

`ifdef ALIGN_CHECK_EN
   logic              err_q, err_d;
   logic              mis;
   assign mis = (d_size == 2'b01 && d_addr[0]) ||
                (d_size[1] && d_addr[1:0] != 2'b00);
`endif

   assign unused = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};

   // Data wins ties unless fetch has already lost STARVE_MAX times in a row
   assign gnt_d = d_req && (!if_req || starve_q != SMAX);
   assign gnt_f = if_req && !gnt_d;
   assign f_n   = (if_addr[1:0] == 2'b00) ? 3'd4 : 3'd1;

   always_comb begin
      dn  = 3'd4;
      wal = d_wdata;
      unique case (d_size)
         2'b00: begin
            dn  = 3'd1;
            wal = {d_wdata[7:0], 24'd0};
         end
         2'b01: begin
            dn  = 3'd2;
            wal = {d_wdata[15:0], 16'd0};
         end
         default: begin
            dn  = 3'd4;
            wal = d_wdata;
         end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      dsel_d     = dsel_q;
      base_d     = base_q;
      rw_d       = rw_q;
      wbuf_d     = wbuf_q;
      n_d        = n_q;
      k_d        = k_q;
      acc_d      = acc_q;
      starve_d   = starve_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
`ifdef ALIGN_CHECK_EN
      err_d      = err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (gnt_d || gnt_f) begin
               dsel_d  = gnt_d;
               base_d  = gnt_d ? d_addr[ADDR_W-1:0]
                               : if_addr[ADDR_W-1:0];
               rw_d    = gnt_d && d_rw;
               n_d     = gnt_d ? dn : f_n;
               wbuf_d  = wal;
               k_d     = 3'd0;
               acc_d   = 24'd0;
               state_d = S_XFER;
               if (gnt_f)
                  starve_d = '0;
               else if (if_req && starve_q != SMAX)
                  starve_d = starve_q + 1'b1;
`ifdef ALIGN_CHECK_EN
               err_d = 1'b0;
               if (gnt_d && mis) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end
`endif
            end
         end
         S_XFER: begin
            k_d    = k_q + 3'd1;
            wbuf_d = {wbuf_q[23:0], 8'd0};
            acc_d  = {acc_q[15:0], mem_rdata};
            if (k_q == n_q - 3'd1) begin
               state_d = S_DONE;
               if (!rw_q) begin
                  if (dsel_q)
                     d_rdata_d = {acc_q, mem_rdata};
                  else
                     if_rdata_d = {acc_q, mem_rdata};
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         dsel_q     <= 1'b0;
         base_q     <= '0;
         rw_q       <= 1'b0;
         wbuf_q     <= '0;
         n_q        <= '0;
         k_q        <= '0;
         acc_q      <= '0;
         starve_q   <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
`ifdef ALIGN_CHECK_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         dsel_q     <= dsel_d;
         base_q     <= base_d;
         rw_q       <= rw_d;
         wbuf_q     <= wbuf_d;
         n_q        <= n_d;
         k_q        <= k_d;
         acc_q      <= acc_d;
         starve_q   <= starve_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
`ifdef ALIGN_CHECK_EN
         err_q      <= err_d;
`endif
      end
   end

   assign mem_en    = (state_q == S_XFER);
   assign mem_we    = mem_en && rw_q;
   assign mem_addr  = base_q + ADDR_W'(k_q);
   assign mem_wdata = wbuf_q[31:24];
   assign if_valid  = (state_q == S_DONE) && !dsel_q;
   assign d_valid   = (state_q == S_DONE) && dsel_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = (state_q != S_IDLE);
`ifdef ALIGN_CHECK_EN
   assign d_err     = d_valid && err_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction model plus directed
// and randomized fetch/data traffic (honours ALIGN_CHECK_EN if defined).
module tb_mem_port_arbiter;

   localparam int SMAX = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_valid;
   logic [31:0] if_rdata;
   logic        d_req, d_rw;
   logic [1:0]  d_size;
   logic [31:0] d_addr, d_wdata;
   logic        d_valid;
   logic [31:0] d_rdata;
   logic        mem_en, mem_we;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata;
   logic        busy;
`ifdef ALIGN_CHECK_EN
   logic        d_err;
`endif

   logic [7:0]  mem [256];
   logic [7:0]  ref_mem [256];
   logic        fill, pl_en;
   logic [7:0]  pl_addr, pl_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(8), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr),
      .if_valid(if_valid), .if_rdata(if_rdata),
      .d_req(d_req), .d_rw(d_rw), .d_size(d_size),
      .d_addr(d_addr), .d_wdata(d_wdata),
      .d_valid(d_valid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
`ifdef ALIGN_CHECK_EN
      .d_err(d_err),
`endif
      .busy(busy)
   );

   function automatic logic [7:0] pat(input int i);
      return 8'((i * 7 + 3) & 255);
   endfunction

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      end else if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (mem_en && mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level reference model and per-cycle compare
   bit          m_act = 0;
   int          m_g, m_n, m_base, m_starve = 0, cyc = 0;
   bit          m_dsel, m_rw, m_err;
   logic [31:0] m_wdata, m_res;
   logic [31:0] m_if_rd = 0, m_d_rd = 0;

   always @(negedge clk) begin
      int p, k, ea;
      bit e_en, e_we, e_ifv, e_dv, e_err, e_busy, fin, take_d;
      logic [7:0] e_wd;
      if (!reset_n) begin
         chk("reset_outs", 32'({mem_en, mem_we, if_valid, d_valid, busy,
                                mem_addr, mem_wdata}), 32'd0);
         chk("reset_if_rdata", if_rdata, 32'd0);
         chk("reset_d_rdata", d_rdata, 32'd0);
`ifdef ALIGN_CHECK_EN
         chk("reset_d_err", 32'(d_err), 32'd0);
`endif
         m_act = 0; m_starve = 0; m_if_rd = 0; m_d_rd = 0;
      end else begin
         if (fill) for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
         if (pl_en) ref_mem[pl_addr] = pl_data;
         e_en = 0; e_we = 0; e_ifv = 0; e_dv = 0; e_err = 0;
         e_busy = 0; fin = 0; ea = 0; e_wd = 0;
         if (m_act) begin
            p = cyc - m_g;
            e_busy = 1;
            if (p <= m_n) begin
               k = p - 1;
               e_en = 1;
               e_we = m_rw;
               ea = (m_base + k) & 255;
               e_wd = 8'(m_wdata >> (8 * (m_n - 1 - k)));
               if (m_rw) ref_mem[ea] = e_wd;
            end else begin
               fin = 1;
               if (m_dsel) begin
                  e_dv = 1;
                  e_err = m_err;
                  if (!m_rw && !m_err) m_d_rd = m_res;
               end else begin
                  e_ifv = 1;
                  m_if_rd = m_res;
               end
            end
         end
         chk("mem_en", 32'(mem_en), 32'(e_en));
         chk("mem_we", 32'(mem_we), 32'(e_we));
         if (e_en) chk("mem_addr", 32'(mem_addr), 32'(ea));
         if (e_en && e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
         chk("if_valid", 32'(if_valid), 32'(e_ifv));
         chk("d_valid", 32'(d_valid), 32'(e_dv));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("if_rdata", if_rdata, m_if_rd);
         chk("d_rdata", d_rdata, m_d_rd);
`ifdef ALIGN_CHECK_EN
         chk("d_err", 32'(d_err), 32'(e_err));
`endif
         if (fin) begin
            m_act = 0;
         end else if (!m_act && (if_req || d_req)) begin
            take_d = d_req && !(if_req && m_starve == SMAX);
            m_err = 0;
            if (take_d) begin
               if (if_req && m_starve < SMAX) m_starve++;
               m_dsel = 1;
               m_base = int'(d_addr[7:0]);
               m_rw = d_rw;
               m_n = (d_size == 2'b00) ? 1 : (d_size == 2'b01) ? 2 : 4;
               m_wdata = d_wdata;
`ifdef ALIGN_CHECK_EN
               if ((m_n == 2 && d_addr[0]) ||
                   (m_n == 4 && d_addr[1:0] != 2'b00)) begin
                  m_err = 1;
                  m_n = 0;
                  m_rw = 0;
               end
`endif
            end else begin
               m_starve = 0;
               m_dsel = 0;
               m_base = int'(if_addr[7:0]);
               m_rw = 0;
               m_n = (if_addr[1:0] == 2'b00) ? 4 : 1;
               m_wdata = 0;
            end
            m_res = 0;
            for (int j = 0; j < m_n; j++)
               m_res = m_res + (32'(ref_mem[(m_base + j) & 255])
                                << (8 * (m_n - 1 - j)));
            m_act = 1;
            m_g = cyc;
         end
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_v(input bit is_d, output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!(is_d ? d_valid : if_valid) && lat < 60);
      chk(is_d ? "d_valid_seen" : "if_valid_seen",
          32'(is_d ? d_valid : if_valid), 32'd1);
   endtask

   logic last_err = 0;

   task automatic do_fetch(input logic [31:0] a, output logic [31:0] rd,
                           output int lat);
      tick();
      if_addr = a;
      if_req = 1;
      wait_v(0, lat);
      rd = if_rdata;
      if_req = 0;
   endtask

   task automatic do_data(input bit rw, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
      tick();
      d_rw = rw; d_size = sz; d_addr = a; d_wdata = wd;
      d_req = 1;
      wait_v(1, lat);
      rd = d_rdata;
`ifdef ALIGN_CHECK_EN
      last_err = d_err;
`endif
      d_req = 0;
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] v);
      tick();
      pl_en = 1; pl_addr = a; pl_data = v;
      tick();
      pl_en = 0;
   endtask

   bit exp_order [6] = '{1, 1, 0, 1, 1, 0};

   initial begin
      logic [31:0] rd;
      int lat, n, guard;
      bit order [6];
      reset_n = 0; if_req = 0; if_addr = 0;
      d_req = 0; d_rw = 0; d_size = 0; d_addr = 0; d_wdata = 0;
      fill = 0; pl_en = 0; pl_addr = 0; pl_data = 0;
      repeat (3) tick();
      reset_n = 1;
      tick(); fill = 1;
      tick(); fill = 0;

      preload(8'h10, 8'hE3); preload(8'h11, 8'hA0);
      preload(8'h12, 8'h00); preload(8'h13, 8'h05);
      do_fetch(32'h10, rd, lat);
      chk("word_fetch_data", rd, 32'hE3A00005);
      chk("word_fetch_lat", 32'(lat), 32'd5);

      do_data(1, 2'b01, 32'h21, 32'h1234ABCD, rd, lat);
      do_data(0, 2'b00, 32'h21, 32'h0, rd, lat);
      chk("byte_load_21", rd, 32'h000000AB);
      do_data(0, 2'b00, 32'h22, 32'h0, rd, lat);
      chk("byte_load_22", rd, 32'h000000CD);
      do_data(0, 2'b10, 32'h20, 32'h0, rd, lat);
      chk("word_load_20", rd, 32'hE3ABCDF8);
`ifndef ALIGN_CHECK_EN
      do_data(1, 2'b10, 32'hFE, 32'hDEADBEEF, rd, lat);
      do_data(0, 2'b11, 32'hFE, 32'h0, rd, lat);
      chk("wrap_word_load", rd, 32'hDEADBEEF);
      do_data(0, 2'b00, 32'h00, 32'h0, rd, lat);
      chk("wrap_byte_00", rd, 32'h000000BE);
      do_data(0, 2'b00, 32'h01, 32'h0, rd, lat);
      chk("wrap_byte_01", rd, 32'h000000EF);
      do_data(0, 2'b00, 32'h02, 32'h0, rd, lat);
      chk("wrap_byte_02_untouched", rd, 32'h00000011);
`else
      do_data(0, 2'b10, 32'h02, 32'h0, rd, lat);
      chk("misalign_err", 32'(last_err), 32'd1);
      chk("misalign_lat", 32'(lat), 32'd1);
      chk("misalign_rdata_kept", rd, 32'hE3ABCDF8);
      do_data(0, 2'b10, 32'h10, 32'h0, rd, lat);
      chk("aligned_no_err", 32'(last_err), 32'd0);
      chk("aligned_word", rd, 32'hE3A00005);
`endif
      preload(8'h13, 8'h7F);
      do_fetch(32'h13, rd, lat);
      chk("misfetch_data", rd, 32'h0000007F);
      chk("misfetch_lat", 32'(lat), 32'd2);

      tick();
      d_rw = 1; d_size = 2'b10; d_addr = 32'h40; d_wdata = 32'h11223344;
      d_req = 1;
      guard = 0;
      do begin
         tick();
         guard++;
      end while (!(mem_en && mem_addr == 8'h42) && guard < 20);
      chk("rst_byte2_reached", 32'(mem_addr), 32'h42);
      reset_n = 0;
      d_req = 0; d_rw = 0;
      #1;
      chk("rst_immediate", 32'({mem_en, mem_we, busy, d_valid}), 32'd0);
      tick(); tick();
      reset_n = 1;
      tick();
      chk("rst_b0", 32'(mem[8'h40]), 32'h11);
      chk("rst_b1", 32'(mem[8'h41]), 32'h22);
      chk("rst_b2", 32'(mem[8'h42]), 32'hD1);
      chk("rst_b3", 32'(mem[8'h43]), 32'hD8);

      tick();
      if_addr = 32'h10; d_addr = 32'h20; d_rw = 0; d_size = 2'b00;
      if_req = 1; d_req = 1;
      n = 0; guard = 0;
      while (n < 6 && guard < 100) begin
         tick();
         guard++;
         if (d_valid || if_valid) begin
            order[n] = d_valid;
            n++;
         end
      end
      if_req = 0; d_req = 0;
      chk("contention_count", 32'(n), 32'd6);
      for (int i = 0; i < n; i++)
         chk("contention_order", 32'(order[i]), 32'(exp_order[i]));

      fork
         begin
            int lf;
            for (int t = 0; t < 40; t++) begin
               repeat ($urandom_range(0, 3)) tick();
               if_addr = $urandom;
               if ($urandom_range(0, 3) != 0) if_addr[1:0] = 2'b00;
               if_req = 1;
               wait_v(0, lf);
               if_req = 0;
            end
         end
         begin
            int ld;
            for (int t = 0; t < 40; t++) begin
               repeat ($urandom_range(0, 3)) tick();
               d_rw = 1'($urandom);
               d_size = 2'($urandom);
               d_addr = $urandom;
               if ($urandom_range(0, 2) == 0)
                  d_addr[7:0] = 8'($urandom_range(250, 255));
               d_wdata = $urandom;
               d_req = 1;
               wait_v(1, ld);
               d_req = 0;
            end
         end
      join

      repeat (4) tick();
      for (int i = 0; i < 256; i++)
         chk("mem_final", 32'(mem[i]), 32'(ref_mem[i]));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
